// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared constants and types for the sprite plotter: visible screen bounds,
//   default sprite edge length, field (erase) colour, the 3-bit colour type and
//   the render FSM state encoding.
//   Optional build macro used by the plotter: SPRITE_SKIP_UNCHANGED_EN.
package sprite_pkg;

  localparam int         SCREEN_W    = 160;
  localparam int         SCREEN_H    = 120;
  localparam int         SPRITE_SIZE = 5;
  localparam logic [2:0] BG_COLOUR   = 3'b010;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_FIN   = 2'd3
  } sprite_state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter
//   Raster counter over a SIZE x SIZE square: dx is the inner index, dy the
//   outer one. Wraps back to (0,0) after the last pixel so consecutive phases
//   start clean even without an explicit clear.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   synchronous active-low reset
//   clr_i   in   force both indices to zero (has priority over en_i)
//   en_i    in   advance one pixel
//   dx_o    out  column offset inside the square
//   dy_o    out  row offset inside the square
//   last_o  out  high while pointing at the final pixel (SIZE-1, SIZE-1)
module sprite_scan_counter #(
  parameter int SIZE = 5,
  parameter int CW   = $clog2(SIZE + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] dx_o,
  output logic [CW-1:0] dy_o,
  output logic          last_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

  logic [CW-1:0] dx_q, dx_d;
  logic [CW-1:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en_i) begin
      if (dx_q == LAST_IDX) begin
        dx_d = '0;
        dy_d = (dy_q == LAST_IDX) ? '0 : dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_o   = dx_q;
  assign dy_o   = dy_q;
  assign last_o = (dx_q == LAST_IDX) && (dy_q == LAST_IDX);

endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter
//   Renders one player's square sprite into the VGA adapter's pixel-write
//   port. Each accepted request first erases the square at the previously
//   drawn position (field colour), then draws the square at the new position
//   in the player colour, one pixel per cycle. Off-screen pixels still take
//   their cycle but are not written.
//   Optional build macro SPRITE_SKIP_UNCHANGED_EN: when defined, a request
//   with the same position and colour as the last render finishes at once
//   without writing any pixel.
// Ports:
//   clock       in   system clock
//   resetn      in   synchronous active-low reset
//   start       in   render request (looked at only while idle)
//   xPos_in     in   new sprite top-left x
//   yPos_in     in   new sprite top-left y
//   colour_in   in   player colour
//   vga_x       out  pixel x
//   vga_y       out  pixel y
//   vga_colour  out  pixel colour
//   plot        out  pixel write enable, one pixel per high cycle
//   busy        out  render in progress
//   done        out  one-cycle completion pulse
//   state_dbg   out  current FSM state (observation only)
//
// Handshake: start is sampled only in IDLE; an accepted start raises busy on
// the next cycle and the inputs are latched, so later changes on start or
// the position/colour inputs have no effect until the render completes.
// done pulses for exactly one cycle in which busy has already dropped; start
// seen during that final FIN cycle is ignored, it is accepted from IDLE on
// the following cycle. Requests are never queued.
module sprite_plotter #(
  parameter int         SIZE      = sprite_pkg::SPRITE_SIZE,
  parameter logic [2:0] BG_COLOUR = sprite_pkg::BG_COLOUR,
  parameter int         SCREEN_W  = sprite_pkg::SCREEN_W,
  parameter int         SCREEN_H  = sprite_pkg::SCREEN_H
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [7:0]                xPos_in,
  input  logic [6:0]                yPos_in,
  input  sprite_pkg::colour_t       colour_in,
  output logic [7:0]                vga_x,
  output logic [6:0]                vga_y,
  output sprite_pkg::colour_t       vga_colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      done,
  output sprite_pkg::sprite_state_e state_dbg
);

  import sprite_pkg::*;

  localparam int CW = $clog2(SIZE + 1);

  sprite_state_e state_q;
  logic [7:0]    new_x_q, old_x_q;
  logic [6:0]    new_y_q, old_y_q;
  colour_t       colour_q;
  logic          old_valid_q;
`ifdef SPRITE_SKIP_UNCHANGED_EN
  colour_t       old_colour_q;
`endif

  logic [7:0]    vga_x_q;
  logic [6:0]    vga_y_q;
  colour_t       vga_colour_q;
  logic          plot_q, busy_q, done_q;

  logic [CW-1:0] dx, dy;
  logic          scan_last;
  logic          scanning;

  assign scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  // Counter runs only while a phase is scanning; it wraps on its own at the
  // ERASE->DRAW boundary and is held clear everywhere else.
  sprite_scan_counter #(
    .SIZE (SIZE),
    .CW   (CW)
  ) u_scan (
    .clk_i  (clock),
    .rst_ni (resetn),
    .clr_i  (!scanning),
    .en_i   (scanning),
    .dx_o   (dx),
    .dy_o   (dy),
    .last_o (scan_last)
  );

  // Pixel address: sums carry one extra bit so a carry out is also clipped.
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_view;
  colour_t    pix_colour;

  assign base_x     = (state_q == ST_ERASE) ? old_x_q : new_x_q;
  assign base_y     = (state_q == ST_ERASE) ? old_y_q : new_y_q;
  assign sum_x      = {1'b0, base_x} + 9'(dx);
  assign sum_y      = {1'b0, base_y} + 8'(dy);
  assign in_view    = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
  assign pix_colour = (state_q == ST_ERASE) ? BG_COLOUR : colour_q;

  logic skip_req;
`ifdef SPRITE_SKIP_UNCHANGED_EN
  assign skip_req = old_valid_q && (xPos_in == old_x_q) &&
                    (yPos_in == old_y_q) && (colour_in == old_colour_q);
`else
  assign skip_req = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      new_x_q      <= '0;
      new_y_q      <= '0;
      colour_q     <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      old_valid_q  <= 1'b0;
`ifdef SPRITE_SKIP_UNCHANGED_EN
      old_colour_q <= '0;
`endif
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            new_x_q  <= xPos_in;
            new_y_q  <= yPos_in;
            colour_q <= colour_in;
            busy_q   <= 1'b1;
            if (skip_req)         state_q <= ST_FIN;
            else if (old_valid_q) state_q <= ST_ERASE;
            else                  state_q <= ST_DRAW;
          end
        end
        ST_ERASE, ST_DRAW: begin
          vga_x_q      <= sum_x[7:0];
          vga_y_q      <= sum_y[6:0];
          vga_colour_q <= pix_colour;
          plot_q       <= in_view;
          if (scan_last) begin
            state_q <= (state_q == ST_ERASE) ? ST_DRAW : ST_FIN;
          end
        end
        ST_FIN: begin
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          old_x_q      <= new_x_q;
          old_y_q      <= new_y_q;
          old_valid_q  <= 1'b1;
`ifdef SPRITE_SKIP_UNCHANGED_EN
          old_colour_q <= colour_q;
`endif
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule
